// File: rtl/rx_link_frame_buf.sv
// rx_link_frame_buf: stores whole frames from the 4B5B receiver in a ring of
// 2^SLOT_W slots, checks CRC-32 inline and queues {length, crc_ok} per frame.
// Optional macro RX_TIMEOUT_EN: drop a frame after TO_CYC idle cycles in RECV.
module rx_link_frame_buf #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned SLOT_W  = 1,
    parameter int unsigned MIN_LEN = 5,
    parameter int unsigned TO_CYC  = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_en,
    input  logic              rx_phaselock,
    input  logic              rx_frame,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              frm_valid,
    output logic [ADDR_W:0]   frm_len,
    output logic              frm_crc_ok,
    input  logic              frm_release,
    output logic              rx_start,
    output logic [1:0]        rx_crc_rslt,
    output logic              rx_busy,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        crc_err_cnt
);
    localparam int unsigned NSLOT = 1 << SLOT_W;
    localparam int unsigned DEPTH = 1 << (SLOT_W + ADDR_W);
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CNT_W = SLOT_W + 1;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_CHECK, S_COMMIT, S_DROP} state_t;

    state_t                        r_state, w_state_nxt;
    logic [7:0]                    r_mem [DEPTH];
    logic [NSLOT-1:0][LEN_W-1:0]   r_stat_len;
    logic [NSLOT-1:0]              r_stat_ok;
    logic                          r_frame_d;
    logic [LEN_W-1:0]              r_wptr, w_wptr_nxt;
    logic [31:0]                   r_crc, w_crc_nxt;
    logic [LEN_W-1:0]              r_len, w_len_nxt;
    logic                          r_ok, w_ok_nxt;
    logic [SLOT_W-1:0]             r_wslot, r_rslot, w_wslot_nxt, w_rslot_nxt;
    logic [CNT_W-1:0]              r_count, w_count_nxt;
    logic [7:0]                    r_rd_data;
    logic                          r_frm_valid, r_frm_ok;
    logic [LEN_W-1:0]              r_frm_len;
    logic                          r_rx_start, r_busy;
    logic [1:0]                    r_crc_rslt, w_rslt_nxt;
    logic [7:0]                    r_drop_cnt, r_crc_err_cnt;
    logic                          w_we, w_start, w_drop, w_commit, w_rel;
    logic                          w_frame_rise, w_frame_fall, w_full, w_slot_full;
    logic [LEN_W-1:0]              w_head_len;
    logic                          w_head_ok;
`ifdef RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0]               r_to_cnt, w_to_cnt_nxt;
`endif

    // Byte-parallel reflected CRC-32 update
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign w_frame_rise = rx_frame & ~r_frame_d;
    assign w_frame_fall = ~rx_frame & r_frame_d;
    assign w_full       = (r_count == CNT_W'(NSLOT));
    assign w_slot_full  = (r_wptr == LEN_W'(1 << ADDR_W));

    // Ring bookkeeping; head status bypasses a commit landing on the new head slot
    assign w_rel       = frm_release & r_frm_valid;
    assign w_rslot_nxt = r_rslot + SLOT_W'(w_rel);
    assign w_wslot_nxt = r_wslot + SLOT_W'(w_commit);
    assign w_count_nxt = r_count + CNT_W'(w_commit) - CNT_W'(w_rel);
    assign w_head_len  = (w_commit && (r_wslot == w_rslot_nxt)) ? r_len : r_stat_len[w_rslot_nxt];
    assign w_head_ok   = (w_commit && (r_wslot == w_rslot_nxt)) ? r_ok  : r_stat_ok[w_rslot_nxt];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state and receive-path control
    always_comb begin
        w_state_nxt = r_state;
        w_wptr_nxt  = r_wptr;
        w_crc_nxt   = r_crc;
        w_len_nxt   = r_len;
        w_ok_nxt    = r_ok;
        w_we        = 1'b0;
        w_start     = 1'b0;
        w_drop      = 1'b0;
        w_commit    = 1'b0;
        w_rslt_nxt  = 2'b00;
`ifdef RX_TIMEOUT_EN
        w_to_cnt_nxt = '0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_frame_rise && rx_en && rx_phaselock) begin
                    if (w_full) begin
                        w_state_nxt = S_DROP;
                        w_drop      = 1'b1;
                    end else begin
                        w_state_nxt = S_RECV;
                        w_wptr_nxt  = '0;
                        w_crc_nxt   = CRC_INIT;
                        w_start     = 1'b1;
                    end
                end
            end
            S_RECV: begin
`ifdef RX_TIMEOUT_EN
                w_to_cnt_nxt = rx_rdy ? '0 : (r_to_cnt + TO_W'(1));
`endif
                if (!rx_phaselock || (rx_rdy && w_slot_full)) begin
                    w_state_nxt = S_DROP;
                    w_drop      = 1'b1;
                end else begin
                    if (rx_rdy) begin
                        w_we       = 1'b1;
                        w_crc_nxt  = crc32_byte(r_crc, rx_data);
                        w_wptr_nxt = r_wptr + LEN_W'(1);
                    end
                    if (rx_done || w_frame_fall) begin
                        w_state_nxt = S_CHECK;
                    end
`ifdef RX_TIMEOUT_EN
                    else if (w_to_cnt_nxt == TO_W'(TO_CYC)) begin
                        w_state_nxt = S_DROP;
                        w_drop      = 1'b1;
                    end
`endif
                end
            end
            S_CHECK: begin
                w_len_nxt   = r_wptr;
                w_ok_nxt    = (r_crc == CRC_RESIDUE) && (r_wptr >= LEN_W'(MIN_LEN));
                w_rslt_nxt  = w_ok_nxt ? 2'b10 : 2'b01;
                w_state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_DROP: begin
                if (!rx_frame) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, status queue, host-side outputs and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_d     <= 1'b0;
            r_wptr        <= '0;
            r_crc         <= '0;
            r_len         <= '0;
            r_ok          <= 1'b0;
            r_wslot       <= '0;
            r_rslot       <= '0;
            r_count       <= '0;
            r_stat_len    <= '0;
            r_stat_ok     <= '0;
            r_rd_data     <= '0;
            r_frm_valid   <= 1'b0;
            r_frm_len     <= '0;
            r_frm_ok      <= 1'b0;
            r_rx_start    <= 1'b0;
            r_crc_rslt    <= 2'b00;
            r_busy        <= 1'b0;
            r_drop_cnt    <= '0;
            r_crc_err_cnt <= '0;
        end else begin
            r_frame_d   <= rx_frame;
            r_wptr      <= w_wptr_nxt;
            r_crc       <= w_crc_nxt;
            r_len       <= w_len_nxt;
            r_ok        <= w_ok_nxt;
            r_wslot     <= w_wslot_nxt;
            r_rslot     <= w_rslot_nxt;
            r_count     <= w_count_nxt;
            if (w_commit) begin
                r_stat_len[r_wslot] <= r_len;
                r_stat_ok[r_wslot]  <= r_ok;
            end
            if (rd_en) r_rd_data <= r_mem[{r_rslot, rd_addr}];
            r_frm_valid <= (w_count_nxt != '0);
            r_frm_len   <= w_head_len;
            r_frm_ok    <= w_head_ok;
            r_rx_start  <= w_start;
            r_crc_rslt  <= w_rslt_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_commit && !r_ok && (r_crc_err_cnt != 8'hFF)) r_crc_err_cnt <= r_crc_err_cnt + 8'd1;
        end
    end

    // Frame memory write port (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (w_we) r_mem[{r_wslot, r_wptr[ADDR_W-1:0]}] <= rx_data;
    end

`ifdef RX_TIMEOUT_EN
    // Inter-byte idle counter, only meaningful in RECV
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_to_cnt <= '0;
        else        r_to_cnt <= w_to_cnt_nxt;
    end
`endif

    assign rd_data     = r_rd_data;
    assign frm_valid   = r_frm_valid;
    assign frm_len     = r_frm_len;
    assign frm_crc_ok  = r_frm_ok;
    assign rx_start    = r_rx_start;
    assign rx_crc_rslt = r_crc_rslt;
    assign rx_busy     = r_busy;
    assign drop_cnt    = r_drop_cnt;
    assign crc_err_cnt = r_crc_err_cnt;

endmodule

// File: tb/tb_rx_link_frame_buf.sv
// tb_rx_link_frame_buf: directed table of frames plus hand-written corner sequences.
module tb_rx_link_frame_buf;
    localparam int unsigned ADDR_W = 4;

    logic              clk, rst_n;
    logic              rx_en, rx_phaselock, rx_frame, rx_rdy, rx_done;
    logic [7:0]        rx_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frm_valid, frm_crc_ok, frm_release;
    logic [ADDR_W:0]   frm_len;
    logic              rx_start, rx_busy;
    logic [1:0]        rx_crc_rslt;
    logic [7:0]        drop_cnt, crc_err_cnt;

    rx_link_frame_buf #(.ADDR_W(ADDR_W), .SLOT_W(1), .MIN_LEN(5), .TO_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx_phaselock(rx_phaselock),
        .rx_frame(rx_frame), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_done(rx_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .frm_valid(frm_valid),
        .frm_len(frm_len), .frm_crc_ok(frm_crc_ok), .frm_release(frm_release),
        .rx_start(rx_start), .rx_crc_rslt(rx_crc_rslt), .rx_busy(rx_busy),
        .drop_cnt(drop_cnt), .crc_err_cnt(crc_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned plen;      // payload bytes before FCS
        logic [7:0]  base;      // payload byte i = base + i
        logic        fcs;       // append correct FCS
        logic        corrupt;   // flip bit 0 of last FCS byte
        logic        commit;    // frame expected to be committed
        logic [1:0]  exp_rslt;
        logic [4:0]  exp_len;
        logic        exp_ok;
    } vec_t;

    localparam int NV = 8;
    vec_t       vecs [NV];
    logic [7:0] fb [20];
    int         flen;
    int         n_vec, n_err;
    int         n_start, n_rslt;
    int         exp_drop, exp_err;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (rx_start) n_start++;
        if (rx_crc_rslt != 2'b00) n_rslt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_model(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, fb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input int idx);
        logic [31:0] c;
        int n;
        n = int'(vecs[idx].plen);
        for (int i = 0; i < n; i++) fb[i] = vecs[idx].base + 8'(i);
        flen = n;
        if (vecs[idx].fcs) begin
            c = crc_model(n);
            for (int k = 0; k < 4; k++) fb[n + k] = c[8*k +: 8];
            if (vecs[idx].corrupt) fb[n + 3] = fb[n + 3] ^ 8'h01;
            flen = n + 4;
        end
    endtask

    // Drive fb[0..flen-1] as one frame; returns right after the rx_done edge
    task automatic send_frame(input int gap_at, input int gap_len, input int en_off, input int lock_off);
        rx_frame = 1'b1;
        tick;
        for (int i = 0; i < flen; i++) begin
            rx_rdy  = 1'b1;
            rx_data = fb[i];
            if (i == en_off) rx_en = 1'b0;
            if (i == lock_off) rx_phaselock = 1'b0;
            tick;
            rx_rdy       = 1'b0;
            rx_phaselock = 1'b1;
            if (i == gap_at) repeat (gap_len) tick;
        end
        rx_done = 1'b1;
        tick;
        rx_done  = 1'b0;
        rx_frame = 1'b0;
        rx_en    = 1'b1;
    endtask

    // Full frame; rslt is rx_crc_rslt two cycles after rx_done; ends after the commit edge
    task automatic run_frame(input int idx, input int gap_at, input int gap_len,
                             input int en_off, input int lock_off, output logic [1:0] rslt);
        build_frame(idx);
        send_frame(gap_at, gap_len, en_off, lock_off);
        tick;
        rslt = rx_crc_rslt;
        tick;
    endtask

    task automatic readback;
        for (int i = 0; i < flen; i++) begin
            rd_en   = 1'b1;
            rd_addr = ADDR_W'(i);
            tick;
            chk("rd_data", 32'(rd_data), 32'(fb[i]));
        end
        rd_en = 1'b0;
    endtask

    task automatic release_head;
        frm_release = 1'b1;
        tick;
        frm_release = 1'b0;
    endtask

    task automatic chk_all_zero;
        chk("z_rd_data", 32'(rd_data), 32'd0);
        chk("z_frm_valid", 32'(frm_valid), 32'd0);
        chk("z_frm_len", 32'(frm_len), 32'd0);
        chk("z_frm_crc_ok", 32'(frm_crc_ok), 32'd0);
        chk("z_rx_start", 32'(rx_start), 32'd0);
        chk("z_rx_crc_rslt", 32'(rx_crc_rslt), 32'd0);
        chk("z_rx_busy", 32'(rx_busy), 32'd0);
        chk("z_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("z_crc_err_cnt", 32'(crc_err_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] got;
        int s_start, s_rslt;

        n_vec = 0; n_err = 0; n_start = 0; n_rslt = 0; exp_drop = 0; exp_err = 0;
        rst_n = 1'b0; rx_en = 1'b1; rx_phaselock = 1'b1; rx_frame = 1'b0; rx_rdy = 1'b0;
        rx_data = 8'h00; rx_done = 1'b0; rd_en = 1'b0; rd_addr = '0; frm_release = 1'b0;

        //               plen   base   fcs   corr  commit rslt   len    ok
        vecs[0] = '{32'd9,  8'h31, 1'b1, 1'b0, 1'b1, 2'b10, 5'd13, 1'b1}; // "123456789"+FCS
        vecs[1] = '{32'd9,  8'h31, 1'b1, 1'b1, 1'b1, 2'b01, 5'd13, 1'b0}; // CB -> CA
        vecs[2] = '{32'd3,  8'h41, 1'b0, 1'b0, 1'b1, 2'b01, 5'd3,  1'b0}; // 3-byte runt
        vecs[3] = '{32'd0,  8'h00, 1'b1, 1'b0, 1'b1, 2'b01, 5'd4,  1'b0}; // FCS only: residue ok, too short
        vecs[4] = '{32'd1,  8'h55, 1'b1, 1'b0, 1'b1, 2'b10, 5'd5,  1'b1}; // exactly MIN_LEN
        vecs[5] = '{32'd12, 8'hA0, 1'b1, 1'b0, 1'b1, 2'b10, 5'd16, 1'b1}; // exactly fills slot
        vecs[6] = '{32'd13, 8'h20, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0,  1'b0}; // 17 bytes: overflow
        vecs[7] = '{32'd4,  8'h10, 1'b1, 1'b0, 1'b1, 2'b10, 5'd8,  1'b1}; // 8-byte good

        // Reset state
        tick;
        chk_all_zero;
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Table of frames, each committed (and released) or dropped
        for (int k = 0; k < NV; k++) begin
            s_start = n_start;
            s_rslt  = n_rslt;
            run_frame(k, -1, 0, -1, -1, got);
            chk("rslt_t2", 32'(got), 32'(vecs[k].exp_rslt));
            chk("rslt_pulse", 32'(rx_crc_rslt), 32'd0);
            chk("busy_after", 32'(rx_busy), 32'd0);
            chk("start_pulses", 32'(n_start - s_start), 32'd1);
            if (vecs[k].commit) begin
                if (vecs[k].exp_rslt == 2'b01) exp_err++;
                chk("frm_valid", 32'(frm_valid), 32'd1);
                chk("frm_len", 32'(frm_len), 32'(vecs[k].exp_len));
                chk("frm_crc_ok", 32'(frm_crc_ok), 32'(vecs[k].exp_ok));
                chk("crc_err_cnt", 32'(crc_err_cnt), 32'(exp_err));
                readback;
                release_head;
                chk("valid_after_rel", 32'(frm_valid), 32'd0);
            end else begin
                exp_drop++;
                chk("drop_frm_valid", 32'(frm_valid), 32'd0);
                chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
                chk("drop_no_rslt", 32'(n_rslt - s_rslt), 32'd0);
            end
        end

        // Two slots full, third frame dropped; FCS bytes and rd_data hold
        run_frame(0, -1, 0, -1, -1, got);
        chk("b_rslt1", 32'(got), 32'h2);
        run_frame(7, -1, 0, -1, -1, got);
        chk("b_rslt2", 32'(got), 32'h2);
        chk("b_head_len", 32'(frm_len), 32'd13);
        rd_en = 1'b1; rd_addr = 4'd12; tick;
        chk("b_fcs_last", 32'(rd_data), 32'hCB);
        rd_en = 1'b0; rd_addr = 4'd9; tick;
        chk("b_rd_hold", 32'(rd_data), 32'hCB);
        rd_en = 1'b1; tick;
        chk("b_fcs_first", 32'(rd_data), 32'h26);
        rd_en = 1'b0;
        s_start = n_start;
        s_rslt  = n_rslt;
        run_frame(0, -1, 0, -1, -1, got);
        exp_drop++;
        chk("b_full_rslt", 32'(got), 32'd0);
        chk("b_full_no_rslt", 32'(n_rslt - s_rslt), 32'd0);
        chk("b_full_no_start", 32'(n_start - s_start), 32'd0);
        chk("b_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        release_head;
        chk("b_valid_f2", 32'(frm_valid), 32'd1);
        chk("b_len_f2", 32'(frm_len), 32'd8);
        rd_en = 1'b1; rd_addr = 4'd0; tick;
        chk("b_rd_f2", 32'(rd_data), 32'h10);
        rd_en = 1'b0;
        release_head;
        chk("b_empty", 32'(frm_valid), 32'd0);

        // Phase lock lost at byte 5
        s_rslt = n_rslt;
        run_frame(0, -1, 0, -1, 4, got);
        exp_drop++;
        chk("d_rslt", 32'(got), 32'd0);
        chk("d_no_rslt", 32'(n_rslt - s_rslt), 32'd0);
        chk("d_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        chk("d_valid", 32'(frm_valid), 32'd0);

        // Release in the same cycle as COMMIT
        run_frame(4, -1, 0, -1, -1, got);
        chk("e_valid_a", 32'(frm_valid), 32'd1);
        build_frame(7);
        send_frame(-1, 0, -1, -1);
        tick;
        chk("e_rslt", 32'(rx_crc_rslt), 32'h2);
        frm_release = 1'b1;
        tick;
        frm_release = 1'b0;
        chk("e_valid_b", 32'(frm_valid), 32'd1);
        chk("e_len_b", 32'(frm_len), 32'd8);
        chk("e_ok_b", 32'(frm_crc_ok), 32'd1);
        release_head;
        chk("e_empty", 32'(frm_valid), 32'd0);

        // rx_en low at start: ignored; rx_en falling mid-frame: frame completes
        s_start = n_start;
        rx_en = 1'b0; rx_frame = 1'b1;
        tick; tick;
        chk("g_busy", 32'(rx_busy), 32'd0);
        chk("g_no_start", 32'(n_start - s_start), 32'd0);
        rx_frame = 1'b0; tick; rx_en = 1'b1; tick;
        chk("g_drop_same", 32'(drop_cnt), 32'(exp_drop));
        run_frame(7, -1, 0, 2, -1, got);
        chk("g_en_fall_rslt", 32'(got), 32'h2);
        chk("g_en_fall_valid", 32'(frm_valid), 32'd1);
        release_head;

        // 17-cycle gap between bytes
        run_frame(7, 1, 17, -1, -1, got);
`ifdef RX_TIMEOUT_EN
        exp_drop++;
        chk("h_to_rslt", 32'(got), 32'd0);
        chk("h_to_valid", 32'(frm_valid), 32'd0);
        chk("h_to_drop", 32'(drop_cnt), 32'(exp_drop));
`else
        chk("h_gap_rslt", 32'(got), 32'h2);
        chk("h_gap_valid", 32'(frm_valid), 32'd1);
        chk("h_gap_len", 32'(frm_len), 32'd8);
        release_head;
`endif

        // Reset mid-frame with a committed frame pending
        run_frame(4, -1, 0, -1, -1, got);
        chk("i_valid_pre", 32'(frm_valid), 32'd1);
        build_frame(7);
        rx_frame = 1'b1; tick;
        rx_rdy = 1'b1; rx_data = fb[0]; tick;
        rx_data = fb[1]; tick;
        rx_rdy = 1'b0;
        #2;
        rst_n = 1'b0; rx_frame = 1'b0;
        #1;
        chk_all_zero;
        @(negedge clk);
        rst_n = 1'b1;
        tick; tick;
        exp_drop = 0; exp_err = 0;
        chk("i_valid_post", 32'(frm_valid), 32'd0);
        run_frame(7, -1, 0, -1, -1, got);
        chk("i_rslt_post", 32'(got), 32'h2);
        chk("i_len_post", 32'(frm_len), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rx_link_frame_buf.md
Name: rx_link_frame_buf

Overview:
Parametrised successor to the single-buffer RX link top. Takes the decoded byte stream from the 4B5B receiver and stores whole frames in a ring of 2^SLOT_W frame slots. Checks CRC-32 inline and queues per-frame status (length, CRC result) for the host.
Single clock domain. The byte-stream inputs are already synchronised to clk by the PHY.

Parameters:
ADDR_W, 11, log2 of slot size in bytes; also the host read-address width
SLOT_W, 1, log2 of slot count (1 = ping-pong)
MIN_LEN, 5, minimum frame length in bytes including 4 FCS bytes
TO_CYC, 1023, inter-byte timeout in clk cycles (used only with RX_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_en  in  1  receive enable, sampled at frame start only
rx_phaselock  in  1  PHY phase lock
rx_frame  in  1  high while a frame is on the line
rx_rdy  in  1  1-cycle byte strobe
rx_data  in  8  byte, valid with rx_rdy
rx_done  in  1  1-cycle end-of-frame pulse
rd_en  in  1  host read strobe
rd_addr  in  ADDR_W  byte offset in head slot
rd_data  out  8  read data
frm_valid  out  1  head slot holds a committed frame
frm_len  out  ADDR_W+1  head frame length in bytes, FCS included
frm_crc_ok  out  1  head frame CRC/length good
frm_release  in  1  1-cycle pulse: free head slot
rx_start  out  1  1-cycle pulse at accepted frame start
rx_crc_rslt  out  2  1-cycle pulse at commit: 10 = good, 01 = bad, else 00
rx_busy  out  1  high in RECV/CHECK/COMMIT/DROP
drop_cnt  out  8  frames dropped, saturating at 255
crc_err_cnt  out  8  bad frames committed, saturating at 255

Behaviour:
- Reset (rst_n low, async):
  - FSM = IDLE.
  - Slot pointers, count, write pointer and counters = 0.
  - All outputs 0; rd_data = 0. Memory contents are not reset.
- Memory: 2^(SLOT_W+ADDR_W) x 8 array.
  - Synchronous write at {wslot,wptr}.
  - Synchronous read at {rslot,rd_addr}. rd_data updates 1 cycle after rd_en and holds while rd_en = 0.
- CRC: CRC-32/IEEE, reflected, init 0xFFFFFFFF, byte-parallel update on each accepted byte. The frame is good when the final register = residue 0xDEBB20E3 and len >= MIN_LEN.
- Frame start is a rising edge of rx_frame (registered previous value).
- IDLE:
  - On frame start with rx_en & rx_phaselock:
    - Slot count = 2^SLOT_W: go to DROP, drop_cnt++.
    - Otherwise: go to RECV, wptr = 0, CRC = init, rx_start pulses.
  - Frame start without rx_en or rx_phaselock: stay in IDLE, no count.
- RECV:
  - Each rx_rdy writes the byte, updates CRC and increments wptr (ADDR_W+1 bits).
  - rx_rdy with wptr = 2^ADDR_W (slot full): byte discarded, go to DROP, drop_cnt++.
  - rx_done or falling rx_frame: go to CHECK. If rx_rdy is in the same cycle, that byte is taken first.
  - rx_phaselock low: go to DROP, drop_cnt++. Takes priority over end-of-frame.
- CHECK (1 cycle): latch len = wptr and ok = residue match & len >= MIN_LEN.
- COMMIT (1 cycle):
  - Store {len, ok} in the status entry of wslot.
  - wslot++ (wraps mod 2^SLOT_W), count++.
  - rx_crc_rslt pulses. crc_err_cnt++ if not ok.
  - Go to IDLE.
  - Bad frames are committed, not dropped.
- DROP: ignore all bytes; return to IDLE when rx_frame = 0. The slot is not committed and wslot is unchanged.
- Commit-to-rx_crc_rslt latency: rx_done at cycle t gives rx_crc_rslt at t+2.
- Read side:
  - frm_valid = (count != 0). frm_len and frm_crc_ok show the status entry at rslot.
  - frm_release with frm_valid: rslot++, count-- on the next edge.
  - frm_release without frm_valid: ignored.
  - Commit and release in the same cycle: count unchanged, both pointers advance.
- rx_en falling mid-frame does not abort the frame in progress.
- Reset mid-frame: the partial frame is lost and the buffer is empty after reset.

Optional Feature:
- RX_TIMEOUT_EN defined:
  - In RECV, a counter clears on each rx_rdy and increments otherwise.
  - Reaching TO_CYC goes to DROP, drop_cnt++.
- RX_TIMEOUT_EN undefined: no counter; RECV waits indefinitely for end-of-frame.

Test Plan:
- Good frame: "123456789" + FCS 26 39 F4 CB, then rx_done -> rx_start pulse, rx_crc_rslt = 10, frm_valid = 1, frm_len = 13, frm_crc_ok = 1, rd_addr 0..12 returns the bytes 1 cycle after rd_en.
- Same frame with last byte CB corrupted to CA -> rx_crc_rslt = 01, frm_crc_ok = 0, crc_err_cnt = 1. A 3-byte frame -> frm_crc_ok = 0.
- SLOT_W = 1: three frames, no release -> frames 1 and 2 committed; frame 3 gives drop_cnt = 1 and no rx_crc_rslt. Then frm_release -> frm_len shows frame 2.
- ADDR_W = 4: 17-byte frame -> DROP, drop_cnt++, frm_valid stays 0, the next 8-byte frame is committed normally.
- rx_phaselock dropped at byte 5 -> drop_cnt++, no commit. frm_release in the same cycle as COMMIT -> count unchanged. rst_n low mid-frame -> all outputs 0.
- RX_TIMEOUT_EN, TO_CYC = 16: 17-cycle gap between bytes -> DROP, drop_cnt++. Without the macro the frame completes and commits.
